// File: rtl/dds_cmd_pkg.sv
// Shared definitions for the DDS command decoder: opcodes, status codes, FSM states
// and the DDS configuration record.
package dds_cmd_pkg;

    localparam logic [7:0] OP_SET_FREQ  = 8'h01;
    localparam logic [7:0] OP_SET_PHASE = 8'h02;
    localparam logic [7:0] OP_SET_WAVE  = 8'h03;
    localparam logic [7:0] OP_SET_AMP   = 8'h04;
    localparam logic [7:0] OP_OUT_EN    = 8'h05;
    localparam logic [7:0] OP_SOFT_RST  = 8'h06;

    localparam logic [7:0] RSP_OK   = 8'h00;
    localparam logic [7:0] RSP_CSUM = 8'hE1;
    localparam logic [7:0] RSP_OPC  = 8'hE2;
    localparam logic [7:0] RSP_ARG  = 8'hE3;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StExec,
        StApply,
        StResp
    } state_e;

    typedef struct packed {
        logic [31:0] freq;
        logic [15:0] phase;
        logic [1:0]  wave;
        logic [7:0]  amp;
        logic        en;
    } dds_cfg_t;

    localparam dds_cfg_t CFG_RESET = '{
        freq:  32'h0,
        phase: 16'h0,
        wave:  2'h0,
        amp:   8'hFF,
        en:    1'b0
    };

    // Reset configuration with a block-specific default amplitude.
    function automatic dds_cfg_t cfg_with_amp(input logic [7:0] amp_default);
        dds_cfg_t cfg;
        cfg     = CFG_RESET;
        cfg.amp = amp_default;
        return cfg;
    endfunction

endpackage

// File: rtl/dds_cmd_check.sv
// Combinational validation of a latched command packet: checksum, opcode and
// argument range, reported in that priority order.
module dds_cmd_check
    import dds_cmd_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [15:0] arg_hi_i,
    input  logic [15:0] arg_lo_i,
    input  logic [7:0]  csum_i,
    output logic        ok_o,
    output logic [7:0]  resp_code_o
);

    logic [7:0] csum_calc;
    logic       op_known;
    logic       arg_legal;

    always_comb begin
        csum_calc = op_i ^ arg_hi_i[15:8] ^ arg_hi_i[7:0] ^ arg_lo_i[15:8] ^ arg_lo_i[7:0];
        op_known  = 1'b1;
        arg_legal = 1'b1;
        unique case (op_i)
            OP_SET_FREQ, OP_SET_PHASE, OP_SOFT_RST: arg_legal = 1'b1;
            OP_SET_WAVE: arg_legal = (arg_hi_i == 16'h0) && (arg_lo_i[15:2] == 14'h0);
            OP_SET_AMP:  arg_legal = (arg_hi_i == 16'h0) && (arg_lo_i[15:8] == 8'h0);
            OP_OUT_EN:   arg_legal = (arg_hi_i == 16'h0) && (arg_lo_i[15:1] == 15'h0);
            default:     op_known  = 1'b0;
        endcase

        ok_o        = 1'b0;
        resp_code_o = RSP_OK;
        if (csum_calc != csum_i) begin
            resp_code_o = RSP_CSUM;
        end else if (!op_known) begin
            resp_code_o = RSP_OPC;
        end else if (!arg_legal) begin
            resp_code_o = RSP_ARG;
        end else begin
            ok_o = 1'b1;
        end
    end

endmodule

// File: rtl/dds_cmd_decoder.sv
// Decodes UART command packets into a shadow DDS configuration, commits it to the
// live registers on dds_sync (or timeout) and returns a status byte via valid/ready.
module dds_cmd_decoder
    import dds_cmd_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT    = 1024,
    parameter bit          APPLY_IMMEDIATE = 1'b0,
    parameter logic [7:0]  AMP_DEFAULT     = 8'hFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        recv_done,
    input  logic [7:0]  dataA,
    input  logic [15:0] dataB,
    input  logic [15:0] dataC,
    input  logic [7:0]  dataD,
    input  logic        dds_sync,
    output logic [31:0] freq_word,
    output logic [15:0] phase_off,
    output logic [1:0]  wave_sel,
    output logic [7:0]  amp,
    output logic        out_en,
    output logic        cfg_update,
    output logic        busy,
    output logic        resp_valid,
    output logic [7:0]  resp_code,
    input  logic        resp_ready,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned   CntW     = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SYNC_TIMEOUT - 1);
    localparam dds_cfg_t      CfgRst   = cfg_with_amp(AMP_DEFAULT);

    state_e          state_q, state_d;
    logic [7:0]      op_q, op_d;
    logic [15:0]     arg_hi_q, arg_hi_d;
    logic [15:0]     arg_lo_q, arg_lo_d;
    logic [7:0]      csum_q, csum_d;
    dds_cfg_t        shadow_q, shadow_d;
    dds_cfg_t        live_q, live_d;
    logic            cfg_update_q, cfg_update_d;
    logic [7:0]      resp_code_q, resp_code_d;
    logic [7:0]      drop_q, drop_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            chk_ok;
    logic [7:0]      chk_code;
    logic            commit;

    dds_cmd_check u_check (
        .op_i        (op_q),
        .arg_hi_i    (arg_hi_q),
        .arg_lo_i    (arg_lo_q),
        .csum_i      (csum_q),
        .ok_o        (chk_ok),
        .resp_code_o (chk_code)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        arg_hi_d     = arg_hi_q;
        arg_lo_d     = arg_lo_q;
        csum_d       = csum_q;
        shadow_d     = shadow_q;
        live_d       = live_q;
        cfg_update_d = 1'b0;
        resp_code_d  = resp_code_q;
        drop_d       = drop_q;
        cnt_d        = cnt_q;
        commit       = dds_sync || APPLY_IMMEDIATE || (cnt_q == CntLast);

        if (recv_done && (state_q != StIdle) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (recv_done) begin
                    op_d     = dataA;
                    arg_hi_d = dataB;
                    arg_lo_d = dataC;
                    csum_d   = dataD;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (chk_ok) begin
                    state_d = StExec;
                end else begin
                    resp_code_d = chk_code;
                    state_d     = StResp;
                end
            end
            StExec: begin
                unique case (op_q)
                    OP_SET_FREQ:  shadow_d.freq  = {arg_hi_q, arg_lo_q};
                    OP_SET_PHASE: shadow_d.phase = arg_lo_q;
                    OP_SET_WAVE:  shadow_d.wave  = arg_lo_q[1:0];
                    OP_SET_AMP:   shadow_d.amp   = arg_lo_q[7:0];
                    OP_OUT_EN:    shadow_d.en    = arg_lo_q[0];
                    OP_SOFT_RST:  shadow_d       = CfgRst;
                    default:      shadow_d       = shadow_q;
                endcase
                cnt_d   = '0;
                state_d = StApply;
            end
            StApply: begin
                if (commit) begin
                    live_d       = shadow_q;
                    cfg_update_d = 1'b1;
                    resp_code_d  = RSP_OK;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            op_q         <= 8'h0;
            arg_hi_q     <= 16'h0;
            arg_lo_q     <= 16'h0;
            csum_q       <= 8'h0;
            shadow_q     <= CfgRst;
            live_q       <= CfgRst;
            cfg_update_q <= 1'b0;
            resp_code_q  <= RSP_OK;
            drop_q       <= 8'h0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            arg_hi_q     <= arg_hi_d;
            arg_lo_q     <= arg_lo_d;
            csum_q       <= csum_d;
            shadow_q     <= shadow_d;
            live_q       <= live_d;
            cfg_update_q <= cfg_update_d;
            resp_code_q  <= resp_code_d;
            drop_q       <= drop_d;
            cnt_q        <= cnt_d;
        end
    end

    assign freq_word  = live_q.freq;
    assign phase_off  = live_q.phase;
    assign wave_sel   = live_q.wave;
    assign amp        = live_q.amp;
    assign out_en     = live_q.en;
    assign cfg_update = cfg_update_q;
    assign busy       = (state_q != StIdle);
    assign resp_valid = (state_q == StResp);
    assign resp_code  = resp_code_q;
    assign drop_cnt   = drop_q;

endmodule
